// File: rtl/clock_down_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clock_down_multi
//  Purpose  : CHANNELS independent integer clock dividers. Each channel has a
//             double-buffered divisor that is swapped in only at a period
//             boundary. A global sync strobe restarts all channels in phase.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_down_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS*WIDTH-1:0] i_divisor,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic                      i_sync,
    output logic [CHANNELS-1:0]       o_slow_clk,
    output logic [CHANNELS-1:0]       o_rise,
    output logic [CHANNELS-1:0]       o_pending,
    output logic [CHANNELS-1:0]       o_active
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        // Architectural state of one channel
        logic [WIDTH-1:0] r_act;
        logic [WIDTH-1:0] r_pend;
        logic [WIDTH-1:0] r_cnt;
        logic             r_pflag;
        logic             r_out;
        logic             r_rise;
        logic             r_active;

        // Next-state values
        logic [WIDTH-1:0] w_act_nxt;
        logic [WIDTH-1:0] w_pend_nxt;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic             w_pflag_nxt;
        logic             w_out_nxt;
        logic             w_rise_nxt;

        // Helpers derived from current state and this cycle's inputs
        logic [WIDTH-1:0] w_div;
        logic [WIDTH-1:0] w_low_last;
        logic [WIDTH-1:0] w_high_last;
        logic [WIDTH-1:0] w_pend_eff;
        logic             w_pflag_eff;
        logic             w_idle;

        assign w_div       = i_divisor[k*WIDTH +: WIDTH];
        // Divisors 0 and 1 are both "idle": only bit 0 can be set
        assign w_idle      = (r_act[WIDTH-1:1] == '0);
        // Low phase is ceil(N/2) cycles, high phase floor(N/2) cycles
        assign w_low_last  = r_act - (r_act >> 1) - c_ONE;
        assign w_high_last = (r_act >> 1) - c_ONE;
        // A load on the same edge as a boundary or sync takes effect at once
        assign w_pend_eff  = i_load[k] ? w_div : r_pend;
        assign w_pflag_eff = i_load[k] | r_pflag;

        // Next-state: sync restart, idle load, or phase counting
        always_comb begin
            w_act_nxt   = r_act;
            w_pend_nxt  = r_pend;
            w_cnt_nxt   = r_cnt;
            w_pflag_nxt = r_pflag;
            w_out_nxt   = r_out;
            w_rise_nxt  = 1'b0;

            if (i_sync) begin
                if (w_pflag_eff) begin
                    w_act_nxt = w_pend_eff;
                end
                w_pend_nxt  = w_pend_eff;
                w_pflag_nxt = 1'b0;
                w_cnt_nxt   = '0;
                w_out_nxt   = 1'b0;
            end else if (w_idle) begin
                // Idle channel: a load becomes active directly, no pending stage
                w_pflag_nxt = 1'b0;
                w_cnt_nxt   = '0;
                w_out_nxt   = 1'b0;
                if (i_load[k]) begin
                    w_act_nxt = w_div;
                end
            end else begin
                w_pend_nxt  = w_pend_eff;
                w_pflag_nxt = w_pflag_eff;
                if (!r_out) begin
                    if (r_cnt == w_low_last) begin
                        w_out_nxt  = 1'b1;
                        w_rise_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end else if (r_cnt == w_high_last) begin
                    // End of high phase is the only glitch-free swap point
                    w_out_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    if (w_pflag_eff) begin
                        w_act_nxt   = w_pend_eff;
                        w_pflag_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
        end

        // Channel state register with synchronous reset
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_act    <= '0;
                r_pend   <= '0;
                r_cnt    <= '0;
                r_pflag  <= 1'b0;
                r_out    <= 1'b0;
                r_rise   <= 1'b0;
                r_active <= 1'b0;
            end else begin
                r_act    <= w_act_nxt;
                r_pend   <= w_pend_nxt;
                r_cnt    <= w_cnt_nxt;
                r_pflag  <= w_pflag_nxt;
                r_out    <= w_out_nxt;
                r_rise   <= w_rise_nxt;
                r_active <= (w_act_nxt[WIDTH-1:1] != '0);
            end
        end

        assign o_slow_clk[k] = r_out;
        assign o_rise[k]     = r_rise;
        assign o_pending[k]  = r_pflag;
        assign o_active[k]   = r_active;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_down_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_clock_down_multi
//  Purpose  : Directed scoreboard bench for clock_down_multi. Expected
//             {slow_clk, rise} per cycle are queued per channel and popped by
//             an independent monitor; status flags are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_down_multi;

    localparam int WIDTH = 16;
    localparam int CH    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CH*WIDTH-1:0]   i_divisor;
    logic [CH-1:0]         i_load;
    logic                  i_sync;
    logic [CH-1:0]         o_slow_clk;
    logic [CH-1:0]         o_rise;
    logic [CH-1:0]         o_pending;
    logic [CH-1:0]         o_active;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {slow_clk, rise} for consecutive cycles, one queue per channel
    logic [1:0] exp_q [CH][$];

    clock_down_multi #(
        .WIDTH    (WIDTH),
        .CHANNELS (CH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_divisor  (i_divisor),
        .i_load     (i_load),
        .i_sync     (i_sync),
        .o_slow_clk (o_slow_clk),
        .o_rise     (o_rise),
        .o_pending  (o_pending),
        .o_active   (o_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: one expected entry per channel per cycle while entries remain
    always @(negedge clk) begin
        for (int k = 0; k < CH; k++) begin
            if (exp_q[k].size() > 0) begin
                logic [1:0] e;
                e = exp_q[k].pop_front();
                check($sformatf("ch%0d slow/rise", k),
                      {30'b0, o_slow_clk[k], o_rise[k]}, {30'b0, e});
            end
        end
    end

    task automatic push_wave(input int k, input int low, input int high, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < low; i++)  exp_q[k].push_back(2'b00);
            for (int i = 0; i < high; i++) exp_q[k].push_back((i == 0) ? 2'b11 : 2'b10);
        end
    endtask

    task automatic push_idle(input int k, input int n);
        for (int i = 0; i < n; i++) exp_q[k].push_back(2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int k, input logic [WIDTH-1:0] v);
        i_divisor[k*WIDTH +: WIDTH] = v;
    endtask

    function automatic int remaining();
        int s = 0;
        for (int k = 0; k < CH; k++) s += exp_q[k].size();
        return s;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (remaining() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining", remaining(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        i_divisor = '0;
        i_load    = '0;
        i_sync    = 1'b0;
        tick();
        tick();
        check("reset_slow",    o_slow_clk, 0);
        check("reset_rise",    o_rise,     0);
        check("reset_pending", o_pending,  0);
        check("reset_active",  o_active,   0);

        // E0: idle loads ch0=4, ch1=5
        rst = 1'b0;
        set_div(0, 4);
        set_div(1, 5);
        i_load = 4'b0011;
        tick();
        i_load = '0;
        // ch0: N=4 until E8, then N=6 for 3 periods, idle from E26
        push_wave(0, 2, 2, 2);
        push_wave(0, 3, 3, 3);
        push_idle(0, 5);
        // ch1: N=5 for 5 periods, idle from E25
        push_wave(1, 3, 2, 5);
        push_idle(1, 6);
        check("load_active", o_active, 4'b0011);
        check("load_pending", o_pending, 4'b0000);

        // Two loads on active ch0 at E5 and E6: last (6) must win at E8
        repeat (4) tick();
        set_div(0, 10);
        i_load = 4'b0001;
        tick();
        check("pend_e5", o_pending, 4'b0001);
        set_div(0, 6);
        tick();
        i_load = '0;
        check("pend_e6", o_pending, 4'b0001);
        tick();
        check("pend_e7", o_pending, 4'b0001);
        tick();
        check("pend_cleared_e8", o_pending, 4'b0000);
        check("active_e8", o_active, 4'b0011);

        // E21: ch0 <- 1, ch1 <- 0 while active; each finishes its period
        repeat (12) tick();
        set_div(0, 1);
        set_div(1, 0);
        i_load = 4'b0011;
        tick();
        i_load = '0;
        check("idle_pend_e21", o_pending, 4'b0011);
        repeat (4) tick();
        check("idle_active_e25", o_active, 4'b0001);
        check("idle_pend_e25", o_pending, 4'b0001);
        tick();
        check("idle_active_e26", o_active, 4'b0000);
        check("idle_pend_e26", o_pending, 4'b0000);

        // E31: ch2 idle load N=2
        repeat (4) tick();
        set_div(2, 2);
        i_load = 4'b0100;
        tick();
        i_load = '0;
        push_wave(2, 1, 1, 4);
        check("n2_active", o_active, 4'b0100);

        // E40: ch0=4, ch1=6 idle loads; ch2=8 goes pending
        repeat (8) tick();
        set_div(0, 4);
        set_div(1, 6);
        set_div(2, 8);
        i_load = 4'b0111;
        tick();
        i_load = '0;
        check("sync_pre_pending", o_pending, 4'b0100);
        check("sync_pre_active", o_active, 4'b0111);

        // E41: sync together with a load of ch3=3
        set_div(3, 3);
        i_load = 4'b1000;
        i_sync = 1'b1;
        tick();
        i_load = '0;
        i_sync = 1'b0;
        check("sync_slow", o_slow_clk, 4'b0000);
        check("sync_rise", o_rise, 4'b0000);
        check("sync_pending", o_pending, 4'b0000);
        check("sync_active", o_active, 4'b1111);
        push_wave(0, 2, 2, 2);
        push_wave(1, 3, 3, 2);
        push_wave(2, 4, 4, 2);
        push_wave(3, 2, 1, 3);

        // E62: pending load on ch0 while ch2 is in its high phase
        repeat (20) tick();
        set_div(0, 10);
        i_load = 4'b0001;
        tick();
        i_load = '0;
        check("rst_pre_pending", o_pending, 4'b0001);
        check("rst_pre_ch2_high", {31'b0, o_slow_clk[2]}, 1);

        // E63: reset mid-operation
        rst = 1'b1;
        tick();
        check("rst_slow", o_slow_clk, 0);
        check("rst_rise", o_rise, 0);
        check("rst_pending", o_pending, 0);
        check("rst_active", o_active, 0);
        rst = 1'b0;
        tick();
        check("post_rst_pending", o_pending, 0);
        check("post_rst_active", o_active, 0);
        check("post_rst_slow", o_slow_clk, 0);

        // E65: maximum divisor on ch3
        set_div(3, 16'hFFFF);
        i_load = 4'b1000;
        tick();
        i_load = '0;
        push_wave(3, 32768, 32767, 1);
        push_idle(3, 2);
        check("max_active", o_active, 4'b1000);

        drain(70000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
